// File: rtl/acc_stream_16bit.sv
// rtl/acc_stream_16bit.sv - streaming multi-operand accumulator around a 16-bit ripple-of-CLA adder
// Optional signed-overflow tracking is compiled in with `define ACC_SIGNED_OVF_EN.

module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c;
endmodule

module cla_16bit_ripple (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [4:0] c;

    assign c[0] = cin;

    // Carry ripples between 4-bit lookahead slices.
    for (genvar i = 0; i < 4; i++) begin : g_slice
        cla_4bit u_cla (
            .a   (a[4*i +: 4]),
            .b   (b[4*i +: 4]),
            .cin (c[i]),
            .sum (sum[4*i +: 4]),
            .cout(c[i+1])
        );
    end

    assign cout = c[4];
endmodule

module acc_stream_16bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_carry,
    output logic             out_ovf
);
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [15:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cy_q, cy_d;
    logic [15:0]       add_sum;
    logic              add_cout;
    logic              accept;

    cla_16bit_ripple u_adder (
        .a   (acc_q),
        .b   (in_data),
        .cin (1'b0),
        .sum (add_sum),
        .cout(add_cout)
    );

    assign accept = in_valid && (state_q == ST_ACC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (accept && in_last) state_d = ST_HOLD;
            ST_HOLD: if (out_ready)         state_d = ST_ACC;
            default:                        state_d = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_HOLD);
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        cy_d  = cy_q;
        if (state_q == ST_HOLD) begin
            if (out_ready) begin
                acc_d = 16'h0000;
                cnt_d = '0;
                cy_d  = 1'b0;
            end
        end else if (accept) begin
            acc_d = add_sum;
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            cy_d  = cy_q | add_cout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 16'h0000;
            cnt_q <= '0;
            cy_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            cy_q  <= cy_d;
        end
    end

    assign out_sum   = acc_q;
    assign out_cnt   = cnt_q;
    assign out_carry = cy_q;

`ifdef ACC_SIGNED_OVF_EN
    logic ov_q, ov_d;
    logic add_ovf;

    // Operands of equal sign producing a result of the other sign.
    assign add_ovf = (acc_q[15] == in_data[15]) && (add_sum[15] != acc_q[15]);

    always_comb begin
        ov_d = ov_q;
        if (state_q == ST_HOLD) begin
            if (out_ready) ov_d = 1'b0;
        end else if (accept) begin
            ov_d = ov_q | add_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q <= 1'b0;
        end else begin
            ov_q <= ov_d;
        end
    end

    assign out_ovf = ov_q;
`else
    assign out_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_acc_stream_16bit.sv
// tb/tb_acc_stream_16bit.sv - directed self-checking bench for acc_stream_16bit
module tb_acc_stream_16bit;
`ifdef ACC_SIGNED_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic [7:0]  out_cnt;
    logic        out_carry;
    logic        out_ovf;

    logic        in2_valid = 1'b0;
    logic        in2_ready;
    logic [15:0] in2_data = 16'h0000;
    logic        in2_last = 1'b0;
    logic        out2_valid;
    logic        out2_ready = 1'b0;
    logic [15:0] out2_sum;
    logic [1:0]  out2_cnt;
    logic        out2_carry;
    logic        out2_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    acc_stream_16bit #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cnt(out_cnt), .out_carry(out_carry), .out_ovf(out_ovf)
    );

    acc_stream_16bit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data), .in_last(in2_last),
        .out_valid(out2_valid), .out_ready(out2_ready), .out_sum(out2_sum),
        .out_cnt(out2_cnt), .out_carry(out2_carry), .out_ovf(out2_ovf)
    );

    task automatic drive(input logic [15:0] d, input logic last);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL drive_in_ready: got %b want 1 (data %h)", in_ready, d);
            n_fail++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drive2(input logic [15:0] d, input logic last);
        in2_valid = 1'b1;
        in2_data  = d;
        in2_last  = last;
        @(posedge clk);
        #1;
        in2_valid = 1'b0;
        in2_last  = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [15:0] sum, input logic [7:0] cnt,
                                input logic cy, input logic ov);
        n_cmp++;
        if ({out_valid, in_ready, out_sum, out_cnt, out_carry, out_ovf} !== {1'b1, 1'b0, sum, cnt, cy, ov}) begin
            $display("FAIL %s: got valid=%b rdy=%b sum=%h cnt=%0d cy=%b ov=%b want valid=1 rdy=0 sum=%h cnt=%0d cy=%b ov=%b",
                     name, out_valid, in_ready, out_sum, out_cnt, out_carry, out_ovf, sum, cnt, cy, ov);
            n_fail++;
        end
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if ({out_valid, in_ready, out_sum, out_cnt, out_carry, out_ovf} !== {1'b0, 1'b1, 16'h0000, 8'd0, 1'b0, 1'b0}) begin
            $display("FAIL %s: got valid=%b rdy=%b sum=%h cnt=%0d cy=%b ov=%b want idle zeros",
                     name, out_valid, in_ready, out_sum, out_cnt, out_carry, out_ovf);
            n_fail++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_idle("release_idle");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        check_idle("reset_state");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sum3();
        out_ready = 1'b1;
        drive(16'h0001, 1'b0);
        drive(16'h0002, 1'b0);
        drive(16'h0003, 1'b1);
        check_result("sum3", 16'h0006, 8'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_idle("sum3_clear");
    endtask

    task automatic test_carry();
        drive(16'hFFFF, 1'b0);
        drive(16'h0002, 1'b1);
        check_result("carry", 16'h0001, 8'd2, 1'b1, 1'b0);
        release_result();
    endtask

    task automatic test_overflow_and_hold();
        drive(16'h7FFF, 1'b0);
        drive(16'h0001, 1'b1);
        check_result("ovf", 16'h8000, 8'd2, 1'b0, OVF_EN);
        in_valid = 1'b1;
        in_data  = 16'hABCD;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_result("hold_stable", 16'h8000, 8'd2, 1'b0, OVF_EN);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check_idle("bubble_no_accept");
        drive(16'h0005, 1'b1);
        check_result("after_bubble", 16'h0005, 8'd1, 1'b0, 1'b0);
        release_result();
    endtask

    task automatic test_async_reset();
        drive(16'h0100, 1'b0);
        drive(16'h0200, 1'b0);
        n_cmp++;
        if (out_sum !== 16'h0300 || out_cnt !== 8'd2) begin
            $display("FAIL mid_group: got sum=%h cnt=%0d want sum=0300 cnt=2", out_sum, out_cnt);
            n_fail++;
        end
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(16'h0010, 1'b1);
        check_result("post_reset", 16'h0010, 8'd1, 1'b0, 1'b0);
        release_result();
    endtask

    task automatic test_cnt_saturate();
        for (int i = 0; i < 5; i++) drive2(16'h0001, (i == 4));
        n_cmp++;
        if ({out2_valid, out2_sum, out2_cnt, out2_carry} !== {1'b1, 16'h0005, 2'd3, 1'b0}) begin
            $display("FAIL cnt_saturate: got valid=%b sum=%h cnt=%0d cy=%b want valid=1 sum=0005 cnt=3 cy=0",
                     out2_valid, out2_sum, out2_cnt, out2_carry);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_sum3();
        test_carry();
        test_overflow_and_hold();
        test_async_reset();
        test_cnt_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/acc_stream_16bit.md
# acc_stream_16bit

Sequential multi-operand accumulator that sits upstream of and around the 16-bit ripple-of-CLA adder. It accepts a stream of 16-bit operands over a valid/ready handshake and feeds each one plus the running total into one internal `cla_16bit_ripple` instance (cin = 0). It registers the adder's sum and carry-out each cycle. When a group ends, it presents the group total, an operand count and carry/overflow status on an output handshake.

## Interface
- `CNT_W`, default 8: width of the operand counter; the count saturates at 2^CNT_W−1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: the operand on `in_data` is valid.
- `in_ready` output 1: the block can accept an operand this cycle.
- `in_data` input 16: operand, unsigned (two's complement when overflow tracking is compiled in).
- `in_last` input 1: qualifies `in_data` as the final operand of the group.
- `out_valid` output 1: the group result is available.
- `out_ready` input 1: the consumer takes the result this cycle.
- `out_sum` output 16: group total, modulo 2^16.
- `out_cnt` output CNT_W: number of operands accepted in the group (saturating).
- `out_carry` output 1: sticky; set if any addition in the group produced an adder carry-out of 1.
- `out_ovf` output 1: sticky signed-overflow flag (see Configuration).

## Operation
- Two states: ACC and HOLD. Reset state is ACC.
- State only drives `in_ready` and `out_valid`: `in_ready = (state == ACC)` and `out_valid = (state == HOLD)`. There is no combinational path from any input to either of them.
- Internal registers: `acc[15:0]`, `cnt[CNT_W-1:0]`, `cy`, `ov`. The outputs `out_sum`, `out_cnt`, `out_carry` and `out_ovf` are driven directly from these registers.
- Adder inputs: in1 = `acc`, in2 = `in_data`, cin = 0. The adder is combinational and always evaluated.
- ACC state, on accept (`in_valid && in_ready`):
  - `acc` ← adder sum.
  - `cnt` ← `cnt`+1, saturating at all-ones.
  - `cy` ← `cy` OR adder cout.
  - `ov` ← `ov` OR signed overflow (macro only).
  - If `in_last` is 1, go to HOLD.
- ACC state, no accept: all registers hold.
- HOLD state:
  - All registers hold. `in_data`, `in_valid` and `in_last` are ignored.
  - On `out_ready`: `acc`, `cnt`, `cy` and `ov` clear to 0 and the state returns to ACC.
- A one-operand group with `in_last` = 1 gives `out_sum = in_data`, `out_cnt = 1`, `out_carry = 0`.
- An empty group cannot occur; at least one operand precedes HOLD.

## Timing
- Reset values: state ACC, `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_cnt` = 0, `out_carry` = 0, `out_ovf` = 0.
- Reset is asynchronous. Asserting `rst` mid-group or in HOLD discards all accumulated data immediately, with no result emitted.
- Throughput: one operand per cycle in ACC.
- Latency: if the last operand is accepted at edge k, `out_valid` is 1 in the cycle after edge k, and `out_sum` already includes that operand.
- In the HOLD cycle where `out_ready` = 1, `in_ready` is still 0. The earliest next accept is the cycle after, so there is exactly one bubble between groups.
- `out_valid` and the result outputs stay stable while `out_ready` = 0, for any number of cycles.
- `in_valid` with `in_ready` = 0 has no effect. The producer must hold its data until it is accepted.
- Counter wrap: after 2^CNT_W−1 accepts, `cnt` stays at all-ones. `acc` keeps accumulating modulo 2^16.

## Configuration
- `ACC_SIGNED_OVF_EN` defined:
  - Per accept, signed overflow = (`acc[15]` == `in_data[15]`) AND (sum[15] != `acc[15]`).
  - This value is ORed into `ov`, and `out_ovf` reflects `ov`.
- Not defined:
  - The `ov` register and the overflow logic are omitted.
  - `out_ovf` is tied to 0.
  - Everything else is identical.

## Test plan
- Reset, then stream 0x0001, 0x0002, 0x0003 (last) with `out_ready` = 1 → `out_valid` rises one cycle after the third accept with `out_sum` = 0x0006, `out_cnt` = 3, `out_carry` = 0.
- Stream 0xFFFF, 0x0002 (last) → `out_sum` = 0x0001 and `out_carry` = 1. With the macro, `out_ovf` = 0 (−1 + 2).
- With the macro, stream 0x7FFF, 0x0001 (last) → `out_sum` = 0x8000, `out_ovf` = 1, `out_carry` = 0. Without the macro, `out_ovf` = 0.
- Hold `out_ready` = 0 for 5 cycles in HOLD while driving `in_valid` = 1 with junk data → `in_ready` stays 0 and the outputs stay unchanged. Then `out_ready` = 1 → the next group starts from 0 after exactly one bubble.
- Assert `rst` after 2 accepts of a 4-operand group → all outputs return to their reset values immediately. A following group of 0x0010 (last) yields `out_sum` = 0x0010 and `out_cnt` = 1.
- With `CNT_W` = 2, send 5 operands of 0x0001 → `out_cnt` = 3 (saturated) and `out_sum` = 0x0005.
